// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
// The transmit FIFO is built only when UART_TX_FIFO_EN is defined; without
// it a single holding register buffers one byte.
package uart_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Parity selection as presented on the par input.
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } par_mode_e;

  // Line configuration: frame shape plus baud selection.
  typedef struct packed {
    logic      d8;   // 1: eight data bits, 0: seven
    logic      s2;   // 1: two stop bits, 0: one
    logic [1:0] bd;  // divisor select
    par_mode_e par;
  } tx_cfg_t;

  // Clocks per bit at 50 MHz for 115200 / 57600 / 19200 / 9600 baud.
  localparam int unsigned DEF_DIV0 = 434;
  localparam int unsigned DEF_DIV1 = 868;
  localparam int unsigned DEF_DIV2 = 2604;
  localparam int unsigned DEF_DIV3 = 5208;

  // Power-up line setting: 8 data bits, 2 stop bits, slowest rate, even parity.
  localparam tx_cfg_t CFG_RESET = '{d8: 1'b1, s2: 1'b1, bd: 2'b11, par: PAR_EVEN};

  function automatic logic par_enabled(input par_mode_e mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Parity covers only the bits that actually go on the line.
  function automatic logic parity_bit(input logic [7:0] data, input logic d8,
                                      input par_mode_e mode);
    logic p;
    p = d8 ? ^data : ^data[6:0];
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator. tick_o is high during the last clock of each
// bit so the sequencer advances exactly div_i clocks after a bit began.
// reload_i restarts the period so a new frame's start bit is full width.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // End-of-bit detect and next count; the divisor is only compared, never
  // loaded, so a divisor latched on the same edge as the reload is honoured.
  always_comb begin
    tick_o = !reload_i && (cnt_q >= div_i - DIV_W'(1));
    cnt_d  = (reload_i || tick_o) ? '0 : cnt_q + DIV_W'(1);
  end

  // Period counter.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: configurable data bits, stop bits,
// parity and baud divisor, latched per frame. Define UART_TX_FIFO_EN to
// buffer FIFO_DEPTH bytes; otherwise one holding register is used.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV0       = DEF_DIV0,
  parameter int unsigned DIV1       = DEF_DIV1,
  parameter int unsigned DIV2       = DEF_DIV2,
  parameter int unsigned DIV3       = DEF_DIV3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_param,
  input  logic       d_num,
  input  logic       s_num,
  input  logic [1:0] bd_rate,
  input  logic [1:0] par,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       data_out,
  output logic       busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_e        state_q;
  tx_cfg_t          cfg_q, cfg_d;   // programmed setting
  tx_cfg_t          frame_cfg_q;    // setting of the frame on the line
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             stop_cnt_q;
  logic             par_bit_q;
  logic             data_out_q;

  logic             tick;
  logic [DIV_W-1:0] div_sel;
  logic             accept;
  logic             start_idle;
  logic             frame_end;
  logic             have_byte;      // a byte waits to start from IDLE
  logic             more_byte;      // another byte follows the current frame
  logic [7:0]       head_byte;
  logic [7:0]       next_byte;
  logic [7:0]       start_byte;
  logic [2:0]       last_bit;

  assign accept     = data_valid && data_ready;
  assign start_idle = (state_q == ST_IDLE) && have_byte;
  assign frame_end  = (state_q == ST_STOP) && tick && (stop_cnt_q || !frame_cfg_q.s2);
  assign start_byte = (state_q == ST_IDLE) ? head_byte : next_byte;
  assign last_bit   = frame_cfg_q.d8 ? 3'd7 : 3'd6;
  assign busy       = (state_q != ST_IDLE) || have_byte;
  assign data_out   = data_out_q;

  // Configuration load: only honoured while idle so a frame never changes shape.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cfg_d = cfg_q;
    if (!set_param && state_q == ST_IDLE) begin
      cfg_d = '{d8: d_num, s2: s_num, bd: bd_rate, par: par_mode_e'(par)};
    end
  end

  // Programmed configuration register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_q <= CFG_RESET;
    else     cfg_q <= cfg_d;
  end

  // Bit width of the frame in flight.
  always_comb begin
    case (frame_cfg_q.bd)
      2'b00:   div_sel = DIV_W'(DIV0);
      2'b01:   div_sel = DIV_W'(DIV1);
      2'b10:   div_sel = DIV_W'(DIV2);
      default: div_sel = DIV_W'(DIV3);
    endcase
  end

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .reload_i (start_idle),
    .div_i    (div_sel),
    .tick_o   (tick)
  );

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   count_q;
  logic          full;

  // The byte on the line keeps its slot until its frame ends, so a full
  // FIFO holds the frame in flight plus FIFO_DEPTH-1 waiting bytes.
  assign rd_next    = rd_ptr_q + AW'(1);
  assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign data_ready = !rst && !full;
  assign have_byte  = (count_q != '0);
  assign more_byte  = (count_q > (AW+1)'(1));
  assign head_byte  = mem_q[rd_ptr_q];
  assign next_byte  = mem_q[rd_next];

  // FIFO storage.
  // NOTE: storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (frame_end) rd_ptr_q <= rd_next;
      case ({accept, frame_end})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;

  assign data_ready = !rst && (state_q == ST_IDLE) && !hold_valid_q;
  assign have_byte  = hold_valid_q;
  assign more_byte  = 1'b0;
  assign head_byte  = hold_q;
  assign next_byte  = hold_q;

  // Single-byte holding register, emptied as the frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (accept) begin
      hold_q       <= data_in;
      hold_valid_q <= 1'b1;
    end else if (start_idle) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // Frame sequencer with a registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cfg_q <= CFG_RESET;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      par_bit_q   <= 1'b0;
      data_out_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_out_q <= 1'b1;
          if (have_byte) begin
            state_q     <= ST_START;
            data_out_q  <= 1'b0;
            frame_cfg_q <= cfg_d;
            shift_q     <= start_byte;
            par_bit_q   <= parity_bit(start_byte, cfg_d.d8, cfg_d.par);
          end
        end
        ST_START: begin
          if (tick) begin
            state_q    <= ST_DATA;
            data_out_q <= shift_q[0];
            bit_cnt_q  <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == last_bit) begin
              if (par_enabled(frame_cfg_q.par)) begin
                state_q    <= ST_PARITY;
                data_out_q <= par_bit_q;
              end else begin
                state_q    <= ST_STOP;
                data_out_q <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              shift_q    <= {1'b0, shift_q[7:1]};
              data_out_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q    <= ST_STOP;
            data_out_q <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (frame_end) begin
            if (more_byte) begin
              // Chain straight into the next start bit, no idle gap.
              state_q     <= ST_START;
              data_out_q  <= 1'b0;
              frame_cfg_q <= cfg_d;
              shift_q     <= start_byte;
              par_bit_q   <= parity_bit(start_byte, cfg_d.d8, cfg_d.par);
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (tick) begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: stimulus queues expected frames built
// from the line rules; a line monitor decodes data_out and compares.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int D0 = 3;
  localparam int D1 = 5;
  localparam int D2 = 6;
  localparam int D3 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_param;
  logic       d_num;
  logic       s_num;
  logic [1:0] bd_rate;
  logic [1:0] par;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       data_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DIV_W      (8),
    .DIV0       (D0),
    .DIV1       (D1),
    .DIV2       (D2),
    .DIV3       (D3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_param  (set_param),
    .d_num      (d_num),
    .s_num      (s_num),
    .bd_rate    (bd_rate),
    .par        (par),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model of the programmed line setting.
  bit       m_d8;
  bit       m_s2;
  bit [1:0] m_bd;
  bit [1:0] m_par;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
    bit          b2b;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];

  function automatic int div_of(input bit [1:0] bd);
    case (bd)
      2'b00:   return D0;
      2'b01:   return D1;
      2'b10:   return D2;
      default: return D3;
    endcase
  endfunction

  function automatic void model_reset();
    m_d8 = 1'b1; m_s2 = 1'b1; m_bd = 2'b11; m_par = 2'b10;
  endfunction

  // Expected line waveform of one byte under the current model setting.
  function automatic void build_frame(input logic [7:0] b, output exp_t e);
    int n, nd, ones;
    e.data = b; e.div = div_of(m_bd); e.b2b = 1'b0; e.bits = '1;
    n = 0; ones = 0;
    e.bits[n] = 1'b0; n = n + 1;
    nd = m_d8 ? 8 : 7;
    for (int i = 0; i < nd; i++) begin
      e.bits[n] = b[i]; ones = ones + int'(b[i]); n = n + 1;
    end
    if (m_par == 2'b01) begin e.bits[n] = (ones % 2 == 0); n = n + 1; end
    if (m_par == 2'b10) begin e.bits[n] = (ones % 2 == 1); n = n + 1; end
    e.bits[n] = 1'b1; n = n + 1;
    if (m_s2) begin e.bits[n] = 1'b1; n = n + 1; end
    e.nbits = n;
  endfunction

  // Line monitor: decodes frames and compares them against the scoreboard.
  bit          mon_active = 1'b0;
  bit          low_seen   = 1'b0;
  int          ncyc       = 0;
  int          last_end   = -100;
  int          samp, errs, bi;
  exp_t        cur;
  logic [11:0] obs;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      mon_active = 1'b0;
      low_seen   = 1'b0;
    end else begin
      if (!mon_active && data_out === 1'b1) low_seen = 1'b0;
      if (!mon_active && data_out !== 1'b1 && !low_seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(data_out), 32'd1);
          low_seen = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          mon_active = 1'b1; samp = 0; errs = 0; obs = '1;
          if (cur.b2b) check($sformatf("idle_gap_%02h", cur.data), 32'(ncyc - last_end - 1), 32'd0);
        end
      end
      if (mon_active) begin
        bi = samp / cur.div;
        if (data_out !== cur.bits[bi]) errs++;
        if (samp % cur.div == cur.div / 2) obs[bi] = data_out;
        samp++;
        if (samp == cur.nbits * cur.div) begin
          check($sformatf("frame_%02h_bits", cur.data), 32'(obs), 32'(cur.bits));
          check($sformatf("frame_%02h_timing", cur.data), 32'(errs), 32'd0);
          mon_active = 1'b0;
          last_end = ncyc;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    data_in = b; data_valid = 1'b1;
    while (data_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 2000) begin
      check("send_timeout", 32'(guard), 32'd0);
    end else begin
      build_frame(b, e);
      e.b2b = busy;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  // Send one byte and compare how long busy stays high against the frame length.
  task automatic send_timed(input logic [7:0] b);
    exp_t e;
    int   n = 0;
    build_frame(b, e);
    send(b);
    @(negedge clk);
    while (busy === 1'b1 && n < 2000) begin
      n++; @(negedge clk);
    end
    check($sformatf("busy_len_%02h", b), 32'(n), 32'(1 + e.nbits * e.div));
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || mon_active) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 3000) check("idle_timeout", 32'(guard), 32'd0);
  endtask

  task automatic load_cfg(input bit d8, input bit s2, input bit [1:0] bd, input bit [1:0] p);
    @(negedge clk);
    d_num = d8; s_num = s2; bd_rate = bd; par = p; set_param = 1'b0;
    @(negedge clk);
    set_param = 1'b1;
    m_d8 = d8; m_s2 = s2; m_bd = bd; m_par = p;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; set_param = 1'b1; d_num = 1'b0; s_num = 1'b0; bd_rate = 2'b00;
    par = 2'b00; data_in = '0; data_valid = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(data_ready), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(data_ready), 32'd1);

    // Default setting: 8 data, even parity, 2 stops at DIV3.
    send_timed(8'hA5);

    // Data held with data_valid low must not start a frame.
    wait_idle();
    @(negedge clk); data_in = 8'h3C;
    repeat (20) @(negedge clk);
    check("ignored_busy", 32'(busy), 32'd0);

    // 7 data bits, odd parity, 1 stop.
    load_cfg(1'b0, 1'b0, 2'b11, 2'b01);
    send_timed(8'h7F);
    wait_idle();

    // Configuration changes only take effect between frames.
    load_cfg(1'b1, 1'b0, 2'b11, 2'b10);
    send(8'h5A);
    repeat (10) @(negedge clk);
    d_num = 1'b0; par = 2'b00; set_param = 1'b0;
    @(negedge clk); set_param = 1'b1;
    repeat (5) @(negedge clk);
    d_num = 1'b1; s_num = 1'b0; bd_rate = 2'b11; par = 2'b00; set_param = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 2000) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    set_param = 1'b1;
    m_par = 2'b00;
    send(8'h5A);
    wait_idle();

    // Bit width follows the selected divisor.
    load_cfg(1'b1, 1'b0, 2'b00, 2'b00);
    send_timed(8'hC6);
    load_cfg(1'b1, 1'b0, 2'b11, 2'b00);
    send_timed(8'hC6);
    wait_idle();

`ifdef UART_TX_FIFO_EN
    // Fill the FIFO back-to-back; the fifth byte must be refused.
    load_cfg(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      exp_t e;
      @(negedge clk);
      data_in = 8'(i); data_valid = 1'b1;
      if (i <= 4) begin
        check($sformatf("fifo_ready_%0d", i), 32'(data_ready), 32'd1);
        build_frame(8'(i), e);
        e.b2b = (i > 1);
        exp_q.push_back(e);
      end else begin
        check("fifo_full_ready", 32'(data_ready), 32'd0);
      end
      @(posedge clk);
    end
    #1 data_valid = 1'b0;
    wait_idle();
`else
    // Holding register: no acceptance while a frame is on the line.
    send(8'h81);
    repeat (6) @(negedge clk);
    check("hold_ready_busy", 32'(data_ready), 32'd0);
    data_in = 8'hEE; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    wait_idle();
    send(8'h42);
    wait_idle();
`endif

    // Reset during data bit 3 aborts the frame and empties the buffer.
    send(8'hC3);
`ifdef UART_TX_FIFO_EN
    send(8'h99);
`endif
    repeat (4 * div_of(m_bd) - 2) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_data_out", 32'(data_out), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(data_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_empty_busy", 32'(busy), 32'd0);
    check("abort_empty_ready", 32'(data_ready), 32'd1);
    send(8'h3C);
    wait_idle();

    // Randomized settings and bytes.
    for (int k = 0; k < 12; k++) begin
      int nb;
      load_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) send(8'($urandom_range(0, 255)));
      wait_idle();
    end

    wait_idle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning the width of the baud divisor counter.
REQ-002 SHALL have parameters DIV0/DIV1/DIV2/DIV3, defaults 434/868/2604/5208, meaning clocks per bit for bd_rate codes 00/01/10/11 (115200/57600/19200/9600 baud at 50 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the FIFO entries (power of 2, used only with UART_TX_FIFO_EN).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 set_param  in  1  active-low configuration load strobe.
REQ-007 d_num  in  1  data bits: 1=8, 0=7.
REQ-008 s_num  in  1  stop bits: 1=2, 0=1.
REQ-009 bd_rate  in  2  baud code, selects DIV0..DIV3.
REQ-010 par  in  2  parity: 00 none, 01 odd, 10 even, 11 none.
REQ-011 data_in  in  8  byte to send; bit 7 ignored in 7-bit mode.
REQ-012 data_valid  in  1  data_in is offered this cycle.
REQ-013 data_ready  out  1  block accepts data_in this cycle.
REQ-014 data_out  out  1  serial line, idle high.
REQ-015 busy  out  1  frame in progress or data pending.

Function
REQ-016 SHALL accept a byte on any rising edge where data_valid && data_ready; data held with data_valid low SHALL be ignored.
REQ-017 SHALL load the configuration registers from d_num/s_num/bd_rate/par on a rising edge with set_param low, only when the FSM is IDLE; a set_param low while not IDLE SHALL be ignored.
REQ-018 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START when a byte is available; data_out SHALL go low on the edge after acceptance (1-cycle latency).
REQ-020 Each bit SHALL last exactly DIVn clocks; the divisor counter SHALL reload on entry to START so the start bit is full width.
REQ-021 DATA SHALL send LSB first, 8 or 7 bits per the latched d_num; then PARITY if parity is enabled, else STOP.
REQ-022 Parity SHALL be the XOR over transmitted data bits only; odd mode inverts it.
REQ-023 STOP SHALL drive 1 or 2 high bit-times, then return to IDLE, or to START directly when another byte is pending (no idle gap).
REQ-024 Configuration SHALL be latched per frame at START; no field may change mid-frame.
REQ-025 busy SHALL be high from acceptance until the final stop bit-time ends with nothing pending.

Reset
REQ-026 On rst high: data_out=1, data_ready=0 while rst is asserted, busy=0, FSM=IDLE, counters cleared, FIFO emptied.
REQ-027 Configuration reset values: 8 data bits, 2 stop bits, bd_rate=11, even parity.
REQ-028 A reset mid-frame SHALL abort the frame immediately; no partial bits resume after release.

Configuration
REQ-029 Macro UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO buffers bytes; data_ready = !full; simultaneous push and pop when full is not allowed (ready low); push and pop in the same cycle SHALL keep the count unchanged.
REQ-030 Macro UART_TX_FIFO_EN undefined: a single holding register; data_ready = FSM in IDLE and the holding register empty.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the parity-mode enum, and the default divisor constants.
REQ-032 Sub-module uart_baud_gen SHALL generate the bit tick from the selected divisor, with a reload input.

Verification
REQ-033 DIV3=4, defaults, send 0xA5 -> data_out: 0, 1,0,1,0,0,1,0,1, parity 0, 1,1; each bit 4 clocks; 12 bits total = 48 clocks.
REQ-034 Config d_num=0, s_num=0, par=01, send 0x7F -> 0, seven 1s, parity 0, one stop; busy falls after 10 bit-times.
REQ-035 Set_param low mid-frame with par=00 -> the current frame keeps even parity; the next frame has none.
REQ-036 With FIFO, push 0x01,0x02,0x03,0x04,0x05 back-to-back -> data_ready low after the 4th push (5th byte refused); 4 frames sent with no idle gap.
REQ-037 Assert rst during data bit 3 -> data_out=1 at once, busy=0, FIFO empty; after release, a new byte sends a clean frame.
REQ-038 bd_rate=00 vs 11 -> the bit width equals DIV0 vs DIV3 clocks exactly.
